// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package imem_pkg;

  // Default instruction memory capacity in 32-bit words.
  localparam int IMEM_DEPTH_WORDS = 64;

  // Width of the word count in the stream header and of the word index.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Word index to word-aligned byte address, zero-extended to 32 bits.
  function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] idx);
    return {{(32-LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs four stream bytes little-endian into one 32-bit instruction word.
// Latency: packed word visible the cycle after its 4th byte is loaded.
// Backpressure: none; loads only when the owner asserts load.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - accept byte_data into the next byte lane
//   clr         - restart packing at byte lane 0 and zero the word
//   byte_data   - stream byte
//   word_full   - the byte being loaded this cycle completes the word
//   word        - packed word (byte k in bits [8k+7:8k])
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clr,
  input  logic [7:0]  byte_data,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  // Shift in from the top: after four loads the first byte sits in [7:0].
  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clr) begin
      byte_idx_d = 2'd0;
      word_d     = 32'd0;
    end else if (load) begin
      byte_idx_d = byte_idx_q + 2'd1;
      word_d     = {byte_data, word_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Combinational so the FSM can leave DATA on the very cycle the 4th byte
  // is accepted; byte_idx wraps to 0 on its own for the next word.
  assign word_full = load && (byte_idx_q == 2'd3) && !clr;
  assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 16-bit LE word count, then LE-packed words written from addr 0.
// Latency: last byte at t -> we_en at t+1 -> done and cpu_hold release at t+2.
// Backpressure: byte_ready is state-decoded; stalls on byte_valid=0 hold state.
//
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start                  - begin a load (honoured in IDLE or ERR only)
//   byte_valid/byte_data   - incoming byte stream
//   byte_ready             - loader takes the byte this cycle
//   we_en/we_addr/we_data  - instruction memory write port
//   cpu_hold               - core held in reset until a load completes
//   done                   - one-cycle pulse at load completion
//   err                    - sticky: requested length exceeds DEPTH_WORDS
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we_en,
  output logic [31:0] we_addr,
  output logic [31:0] we_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic               loaded_q, loaded_d;

  logic               pk_load, pk_clr, pk_full;
  logic [31:0]        pk_word;
  logic [LEN_W-1:0]   len_full;
  logic [LEN_W-1:0]   word_idx_inc;
  logic               xfer;

  assign xfer         = byte_valid && byte_ready;
  assign len_full     = {byte_data, len_q[7:0]};
  assign word_idx_inc = word_idx_q + 16'd1;

  word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pk_load),
    .clr       (pk_clr),
    .byte_data (byte_data),
    .word_full (pk_full),
    .word      (pk_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      loaded_q   <= loaded_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    loaded_d   = loaded_q;
    pk_load    = 1'b0;
    pk_clr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          loaded_d = 1'b0;
          state_d  = ST_LEN0;
        end
      end
      ST_LEN0: begin
        if (xfer) begin
          len_d   = {len_q[15:8], byte_data};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        // Packer is restarted here so every load begins at byte lane 0.
        pk_clr = 1'b1;
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0) begin
            loaded_d = 1'b1;
            state_d  = ST_DONE;
          end else if (len_full > DEPTH_L) begin
            state_d = ST_ERR;
          end else begin
            word_idx_d = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        pk_load = xfer;
        if (pk_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_inc;
        if (word_idx_inc == len_q) begin
          loaded_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (start) begin
          loaded_d = 1'b0;
          state_d  = ST_LEN0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs. we_addr is only driven during WRITE so it never shows
  // the one-past-the-end index held after the last word.
  assign byte_ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                      (state_q == ST_DATA);
  assign we_en      = (state_q == ST_WRITE);
  assign we_addr    = (state_q == ST_WRITE) ? word_addr(word_idx_q) : 32'd0;
  assign we_data    = pk_word;
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign cpu_hold   = ~loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a write scoreboard.
// Latency: n/a (testbench).
// Backpressure: drives byte_valid with and without gaps.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we_en;
  logic [31:0] we_addr;
  logic [31:0] we_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we_en      (we_en),
    .we_addr    (we_addr),
    .we_data    (we_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  int  cyc      = 0;
  int  done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_en) begin
        wr_t e;
        check("wr_ready_low", {31'd0, byte_ready}, 32'd0);
        check("wr_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", we_addr, e.addr);
          check("wr_data", we_data, e.data);
        end
        wr_cnt++;
      end
      if (done) begin
        check("done_hold_low", {31'd0, cpu_hold}, 32'd0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({pfx, "_we_en"}, {31'd0, we_en}, 32'd0);
    check({pfx, "_we_addr"}, we_addr, 32'd0);
    check({pfx, "_we_data"}, we_data, 32'd0);
    check({pfx, "_done"}, {31'd0, done}, 32'd0);
    check({pfx, "_err"}, {31'd0, err}, 32'd0);
    check({pfx, "_hold"}, {31'd0, cpu_hold}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len, input int gap);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int n;
    n0 = done_cnt;
    n  = 0;
    while (done_cnt == n0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt > n0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_writes", wr_cnt, target);
  endtask

  initial begin
    int t0;
    int w0;
    int d0;
    logic [31:0] words [3];
    words[0] = 32'h00A00213;
    words[1] = 32'h12345678;
    words[2] = 32'hCAFEF00D;

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // One-word load, continuous valid: done 7 cycles after LEN0 entry.
    pulse_start();
    t0 = cyc;
    check("hold_during_load", {31'd0, cpu_hold}, 32'd1);
    send_len(16'd1, 0);
    send_word(32'h00A00213, 32'h0, 0);
    wait_done("one");
    check("one_latency", done_cyc - t0, 32'd7);
    check("one_writes", wr_cnt, 32'd1);

    // Three words with valid toggling every other cycle.
    pulse_start();
    send_len(16'd3, 1);
    for (int i = 0; i < 3; i++) send_word(words[i], 32'(4 * i), 1);
    wait_done("three");
    check("three_writes", wr_cnt, 32'd4);
    check("three_hold", {31'd0, cpu_hold}, 32'd0);

    // Oversize length -> sticky error, remaining input ignored.
    pulse_start();
    send_len(16'd65, 0);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_hold", {31'd0, cpu_hold}, 32'd1);
    check("err_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    check("err_sticky", {31'd0, err}, 32'd1);
    check("err_no_writes", wr_cnt, 32'd4);
    pulse_start();
    check("err_cleared", {31'd0, err}, 32'd0);
    send_len(16'd1, 0);
    send_word(32'hDEADBEEF, 32'h0, 0);
    wait_done("after_err");
    check("after_err_writes", wr_cnt, 32'd5);
    check("after_err_hold", {31'd0, cpu_hold}, 32'd0);

    // Zero-length load.
    d0 = done_cnt;
    pulse_start();
    check("zero_hold_during", {31'd0, cpu_hold}, 32'd1);
    send_len(16'd0, 0);
    wait_done("zero");
    check("zero_no_writes", wr_cnt, 32'd5);
    check("zero_done_count", done_cnt, d0 + 1);
    @(negedge clk);
    check("zero_hold_released", {31'd0, cpu_hold}, 32'd0);

    // Reset after two of three words, then a full reload from address 0.
    pulse_start();
    send_len(16'd3, 0);
    send_word(32'h11111111, 32'h0, 0);
    send_word(32'h22222222, 32'h4, 0);
    wait_writes(7);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    pulse_start();
    send_len(16'd3, 0);
    for (int i = 0; i < 3; i++) send_word(words[2 - i], 32'(4 * i), 0);
    wait_done("reload");
    check("reload_writes", wr_cnt, 32'd10);

    // start pulses during DATA are ignored; original len is honoured.
    d0 = done_cnt;
    pulse_start();
    send_len(16'd2, 0);
    begin
      wr_t e;
      logic [31:0] pw [2];
      pw[0] = 32'hA5A55A5A;
      pw[1] = 32'h0F0F1E1E;
      for (int i = 0; i < 2; i++) begin
        e.addr = 32'(4 * i);
        e.data = pw[i];
        exp_q.push_back(e);
      end
      for (int j = 0; j < 8; j++) begin
        start = (j % 2 == 0);
        send_byte(pw[j / 4][8 * (j % 4) +: 8], 0);
        start = 1'b0;
      end
    end
    wait_done("startdata");
    w0 = wr_cnt;
    check("startdata_writes", w0, 32'd12);
    repeat (10) @(negedge clk);
    check("startdata_idle_ready", {31'd0, byte_ready}, 32'd0);
    check("startdata_single_done", done_cnt, d0 + 1);
    check("startdata_no_extra_writes", wr_cnt, w0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
